exc_flush_ctrl: RTL
===================

# exc_flush_ctrl

Exception/ERET redirect controller that drives the PC register's `flush`/`newpc` pair. It sits beside the MEM stage, arbitrates interrupts, synchronous exceptions and ERET, and owns the minimal CP0 state: BadVAddr, Status, Cause and EPC. Each redirect issues a one-cycle flush pulse with the target PC, then blanks one cycle of events from squashed instructions.

## Interface
Parameters:
- `WIDTH`, 32, PC/data width
- `EXC_VECTOR`, 32'hBFC0_0380, exception entry address

Ports:
- `clk` in 1 — clock
- `rst` in 1 — reset; synchronous, active-high
- `mem_valid` in 1 — real (non-bubble) instruction in MEM
- `exc_valid` in 1 — MEM instruction raised a synchronous exception
- `exc_code` in 5 — ExcCode of that exception
- `exc_pc` in WIDTH — PC of MEM instruction
- `exc_bd` in 1 — MEM instruction is in a branch delay slot
- `exc_badvaddr` in WIDTH — faulting address (AdEL=4/AdES=5)
- `eret` in 1 — MEM instruction is ERET
- `int_pending` in 6 — hardware interrupt lines, level
- `cp0_we` in 1 — MTC0 write strobe
- `cp0_waddr`, `cp0_raddr` in 5 — CP0 register number
- `cp0_wdata` in WIDTH — MTC0 data
- `cp0_rdata` out WIDTH — combinational read of `cp0_raddr`; unmapped = 0
- `flush` out 1 — redirect pulse to PC and pipeline registers
- `newpc` out WIDTH — redirect target, valid while `flush`=1
- `epc`, `status`, `cause` out WIDTH — direct register views

## Operation
- Registers: 8 BadVAddr; 12 Status ([15:8] IM, [1] EXL, [0] IE, others read 0); 13 Cause ([31] BD, [15:10] IP7..2, [6:2] ExcCode, others 0); 14 EPC.
- `Cause[15:10]` samples `int_pending` every cycle. It is read-only to MTC0.
- Interrupt qualifier: `int_req` = IE & ~EXL & |(IM[7:2] & Cause[15:10]) & `mem_valid`.
- Priority within one cycle: `int_req` > `exc_valid` > `eret`. Only one event is taken.
- Exception entry (interrupt uses ExcCode 0):
  - EXL←1
  - EPC ← `exc_bd` ? `exc_pc`−4 : `exc_pc`
  - BD ← `exc_bd`; ExcCode ← code
  - BadVAddr ← `exc_badvaddr` only for codes 4/5
  - `newpc` ← `EXC_VECTOR`
- ERET:
  - EXL←0
  - `newpc` ← current EPC, i.e. the value before this edge
  - ERET with EXL=0 still redirects to EPC.
- MTC0 is suppressed in any cycle where an event is taken. Otherwise it writes the addressed register's writable bits at the edge.
- FSM:
  - IDLE → FLUSH on a taken event.
  - FLUSH (`flush`=1) → SETTLE unconditionally.
  - SETTLE → IDLE unconditionally.
  - In FLUSH and SETTLE, `exc_valid`, `eret`, `int_req` and `cp0_we` are ignored: they belong to squashed instructions.
- `rst` in any state → IDLE, `flush`=0, `newpc`=0, all CP0 registers 0.

## Timing
- Event sampled at the edge ending cycle N. State updates land at that same edge. `flush`=1 and `newpc` are valid for exactly cycle N+1.
- The PC register loads `newpc` at the edge ending N+1.
- Minimum spacing between taken events is 3 cycles (N, N+3).
- `cp0_rdata` reflects writes from the previous edge; there is no bypass.
- Count wraps 0xFFFF_FFFF→0 (when configured). EPC−4 wraps modulo 2^WIDTH.

## Configuration
- `EXC_TIMER_EN` defined:
  - Adds Count (9) and Compare (11), both reset to 0.
  - Count increments every cycle. MTC0 to Count overrides the increment.
  - When Count==Compare and Compare≠0, a sticky timer-interrupt bit is set.
  - Writing Compare clears the sticky bit.
  - `Cause[15]` (IP7) = `int_pending[5]` | timer bit.
- `EXC_TIMER_EN` undefined:
  - Registers 9 and 11 read 0 and ignore writes.
  - IP7 = `int_pending[5]`.

## Test plan
- Reset then idle: `flush`=0, `newpc`=0, `epc`/`status`/`cause`=0 on the first cycle after `rst` deasserts.
- `exc_valid`=1, code=4, `exc_pc`=0x100, `exc_bd`=1, badvaddr=0x33 → next cycle `flush`=1, `newpc`=0xBFC00380. Then EPC=0xFC, Cause=0x8000_0010, BadVAddr=0x33, Status[1]=1.
- MTC0 EPC=0x2000, then `eret` → `flush` pulse with `newpc`=0x2000, EXL=0. An `eret` repeated in the following two cycles is ignored.
- Status=0x0000_0401, `int_pending`=0x01, `mem_valid`=1, with `exc_valid`=1 in the same cycle → interrupt wins: ExcCode=0, EPC=`exc_pc`.
- `exc_valid` and `cp0_we` (Status ← 0) in the same cycle → Status keeps its prior IM/IE with EXL=1. Assert `rst` during FLUSH → `flush`=0 the next cycle, state IDLE.
- With `EXC_TIMER_EN`: Compare=5, IE=1, IM7=1 → the interrupt fires within 6 cycles of the Compare write. Rewriting Compare clears IP7.

Source files
------------

// File: rtl/exc_flush_ctrl.sv
// Exception/ERET redirect controller with minimal CP0 (BadVAddr, Status, Cause, EPC).
// Optional Count/Compare timer interrupt on IP7 when EXC_TIMER_EN is defined.
module exc_flush_ctrl #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             exc_valid,
    input  logic [4:0]       exc_code,
    input  logic [WIDTH-1:0] exc_pc,
    input  logic             exc_bd,
    input  logic [WIDTH-1:0] exc_badvaddr,
    input  logic             eret,
    input  logic [5:0]       int_pending,
    input  logic             cp0_we,
    input  logic [4:0]       cp0_waddr,
    input  logic [4:0]       cp0_raddr,
    input  logic [WIDTH-1:0] cp0_wdata,
    output logic [WIDTH-1:0] cp0_rdata,
    output logic             flush,
    output logic [WIDTH-1:0] newpc,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] status,
    output logic [WIDTH-1:0] cause
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StFlush  = 2'd1;
    localparam logic [1:0] StSettle = 2'd2;

    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] badvaddr_q, epc_q, newpc_q;
    logic [7:0]       im_q;
    logic             exl_q, ie_q, bd_q;
    logic [5:0]       ip_q, ip_d;
    logic [4:0]       exc_code_q;
    logic             ip7;

    logic idle, int_req, take_int, take_exc, take_eret, take, cp0_wr;

    assign idle      = (state_q == StIdle);
    assign int_req   = ie_q & ~exl_q & (|(im_q[7:2] & ip_q)) & mem_valid;
    // Only IDLE accepts events; later cycles belong to squashed instructions.
    assign take_int  = idle & int_req;
    assign take_exc  = idle & ~int_req & exc_valid;
    assign take_eret = idle & ~int_req & ~exc_valid & eret;
    assign take      = take_int | take_exc | take_eret;
    assign cp0_wr    = idle & ~take & cp0_we;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (take) state_d = StFlush;
            StFlush:  state_d = StSettle;
            StSettle: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

`ifdef EXC_TIMER_EN
    logic [WIDTH-1:0] count_q, compare_q;
    logic             timer_q, timer_d;

    always_comb begin
        timer_d = timer_q;
        if (cp0_wr && cp0_waddr == RegCompare) begin
            timer_d = 1'b0;
        end else if (count_q == compare_q && compare_q != '0) begin
            timer_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            timer_q   <= 1'b0;
        end else begin
            count_q   <= (cp0_wr && cp0_waddr == RegCount) ? cp0_wdata : count_q + WIDTH'(1);
            if (cp0_wr && cp0_waddr == RegCompare) compare_q <= cp0_wdata;
            timer_q   <= timer_d;
        end
    end

    // Use the next sticky value so the timer reaches Cause one edge earlier.
    assign ip7 = int_pending[5] | timer_d;
`else
    assign ip7 = int_pending[5];
`endif

    assign ip_d = {ip7, int_pending[4:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            badvaddr_q <= '0;
            epc_q      <= '0;
            newpc_q    <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= '0;
            exc_code_q <= '0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            if (take_int || take_exc) begin
                exl_q      <= 1'b1;
                epc_q      <= exc_bd ? exc_pc - WIDTH'(4) : exc_pc;
                bd_q       <= exc_bd;
                exc_code_q <= take_int ? 5'd0 : exc_code;
                if (take_exc && (exc_code == 5'd4 || exc_code == 5'd5)) begin
                    badvaddr_q <= exc_badvaddr;
                end
                newpc_q    <= EXC_VECTOR;
            end else if (take_eret) begin
                exl_q   <= 1'b0;
                newpc_q <= epc_q;
            end else if (cp0_wr) begin
                case (cp0_waddr)
                    RegBadVAddr: badvaddr_q <= cp0_wdata;
                    RegStatus: begin
                        im_q  <= cp0_wdata[15:8];
                        exl_q <= cp0_wdata[1];
                        ie_q  <= cp0_wdata[0];
                    end
                    RegCause: begin
                        bd_q       <= cp0_wdata[31];
                        exc_code_q <= cp0_wdata[6:2];
                    end
                    RegEpc:  epc_q <= cp0_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign status = WIDTH'({16'b0, im_q, 6'b0, exl_q, ie_q});
    assign cause  = WIDTH'({bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0});
    assign epc    = epc_q;
    assign flush  = (state_q == StFlush);
    assign newpc  = newpc_q;

    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            RegBadVAddr: cp0_rdata = badvaddr_q;
            RegStatus:   cp0_rdata = status;
            RegCause:    cp0_rdata = cause;
            RegEpc:      cp0_rdata = epc_q;
`ifdef EXC_TIMER_EN
            RegCount:    cp0_rdata = count_q;
            RegCompare:  cp0_rdata = compare_q;
`endif
            default:     cp0_rdata = '0;
        endcase
    end

endmodule
